// File: rtl/csa_seq_pkg.sv
// Shared types and constants for the byte-serial add/subtract sequencer.
package csa_seq_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int   BYTE_W = 8;
   localparam logic ID_R0  = 1'b0;
   localparam logic ID_R1  = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that was not served last.
module rr_arb2
   import csa_seq_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] grant,
   output logic       id
);
   always_comb begin
      id    = ID_R0;
      grant = 2'b00;
      case (valid)
         2'b01:   id = ID_R0;
         2'b10:   id = ID_R1;
         2'b11:   id = ~last;
         default: id = ID_R0;
      endcase
      if (valid != 2'b00)
         grant = (id == ID_R1) ? 2'b10 : 2'b01;
   end
endmodule

// File: rtl/csa_seq_ctrl.sv
// Shares one external 8-bit adder slice between two requesters, sequencing
// multi-byte add/subtract LSB first with the carry chained through a register.
module csa_seq_ctrl
   import csa_seq_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    r0_valid,
   output logic                    r0_ready,
   input  logic [BYTE_W*WORDS-1:0] r0_a,
   input  logic [BYTE_W*WORDS-1:0] r0_b,
   input  logic                    r0_sub,
   input  logic                    r1_valid,
   output logic                    r1_ready,
   input  logic [BYTE_W*WORDS-1:0] r1_a,
   input  logic [BYTE_W*WORDS-1:0] r1_b,
   input  logic                    r1_sub,
   output logic [BYTE_W-1:0]       add_a,
   output logic [BYTE_W-1:0]       add_b,
   output logic                    add_cin,
   input  logic [BYTE_W-1:0]       add_sum,
   input  logic                    add_cout,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [BYTE_W*WORDS-1:0] rsp_sum,
   output logic                    rsp_cout,
   output logic                    rsp_ovf,
   output logic                    rsp_id
);
   localparam int W     = BYTE_W * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_t           state_reg;
   logic [W-1:0]     op_a_reg, op_b_reg, res_reg;
   logic             sub_reg, id_reg, last_reg, carry_reg, ovf_reg;
   logic [IDX_W-1:0] idx_reg;

   logic [1:0]        grant;
   logic              grant_id, idle, run, done, accept;
   logic [W-1:0]      sel_a, sel_b;
   logic              sel_sub;
   logic [BYTE_W-1:0] a_bytes [WORDS];
   logic [BYTE_W-1:0] b_bytes [WORDS];
   logic [BYTE_W-1:0] cur_a, cur_b;

   rr_arb2 u_arb (
      .valid ({r1_valid, r0_valid}),
      .last  (last_reg),
      .grant (grant),
      .id    (grant_id)
   );

   generate
      for (genvar gi = 0; gi < WORDS; gi++) begin : g_bytes
         assign a_bytes[gi] = op_a_reg[gi*BYTE_W +: BYTE_W];
         assign b_bytes[gi] = op_b_reg[gi*BYTE_W +: BYTE_W];
      end
   endgenerate

   // Ready is gated by rst so it reads 0 the instant reset asserts.
   assign idle     = (state_reg == IDLE) && !rst;
   assign run      = (state_reg == RUN);
   assign done     = (state_reg == DONE);
   assign r0_ready = idle && grant[0];
   assign r1_ready = idle && grant[1];
   assign accept   = idle && (grant != 2'b00);

   assign sel_a   = grant_id ? r1_a   : r0_a;
   assign sel_b   = grant_id ? r1_b   : r0_b;
   assign sel_sub = grant_id ? r1_sub : r0_sub;

   always_comb begin
      cur_a = '0;
      cur_b = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (idx_reg == IDX_W'(i)) begin
            cur_a = a_bytes[i];
            cur_b = b_bytes[i];
         end
      end
   end

   assign add_a   = run ? cur_a : '0;
   assign add_b   = run ? cur_b : '0;
   assign add_cin = run && ((idx_reg == '0) ? sub_reg : carry_reg);

   assign rsp_valid = done;
   assign rsp_sum   = done ? res_reg : '0;
   assign rsp_cout  = done && carry_reg;
   assign rsp_ovf   = done && ovf_reg;
   assign rsp_id    = done && id_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         op_a_reg  <= '0;
         op_b_reg  <= '0;
         res_reg   <= '0;
         sub_reg   <= 1'b0;
         id_reg    <= 1'b0;
         last_reg  <= 1'b1;
         carry_reg <= 1'b0;
         ovf_reg   <= 1'b0;
         idx_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  op_a_reg  <= sel_a;
                  op_b_reg  <= sel_b ^ {W{sel_sub}};
                  sub_reg   <= sel_sub;
                  id_reg    <= grant_id;
                  last_reg  <= grant_id;
                  idx_reg   <= '0;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < WORDS; i++) begin
                  if (idx_reg == IDX_W'(i))
                     res_reg[i*BYTE_W +: BYTE_W] <= add_sum;
               end
               carry_reg <= add_cout;
               idx_reg   <= idx_reg + 1'b1;
               if (idx_reg == LAST_IDX) begin
                  // opB is already inverted for subtract, so one rule covers both.
                  ovf_reg   <= (op_a_reg[W-1] == op_b_reg[W-1]) &&
                               (add_sum[BYTE_W-1] != op_a_reg[W-1]);
                  state_reg <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_csa_seq_ctrl.sv
// Scoreboard bench for csa_seq_ctrl: expected results are queued at accept
// time and compared when the response handshake occurs.
module tb_csa_seq_ctrl;
   localparam int WORDS = 4;
   localparam int W     = 8 * WORDS;

   logic         clk = 1'b0;
   logic         rst;
   logic         r0_valid, r0_ready, r0_sub;
   logic         r1_valid, r1_ready, r1_sub;
   logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
   logic [7:0]   add_a, add_b, add_sum;
   logic         add_cin, add_cout;
   logic         rsp_valid, rsp_ready, rsp_cout, rsp_ovf, rsp_id;
   logic [W-1:0] rsp_sum;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         id;
   } rsp_t;

   rsp_t sb_q[$];
   int   acc_ids[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   acc_cyc = 0;
   int   rsp_hs_cyc = 0;
   logic prev_rsp_valid = 1'b0;
   rsp_t e;

   always #5 clk = ~clk;

   // External combinational adder slice.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

   csa_seq_ctrl #(.WORDS(WORDS)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sub(r0_sub),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sub(r1_sub),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
      .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_id(rsp_id)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic rsp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic id);
      rsp_t       m;
      logic [W:0] ext;
      ext    = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      m.sum  = ext[W-1:0];
      m.cout = sub ? ~ext[W] : ext[W];
      if (sub) m.ovf = (a[W-1] != b[W-1]) && (ext[W-1] != a[W-1]);
      else     m.ovf = (a[W-1] == b[W-1]) && (ext[W-1] != a[W-1]);
      m.id   = id;
      return m;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (r0_valid && r0_ready) begin
            sb_q.push_back(model(r0_a, r0_b, r0_sub, 1'b0));
            acc_ids.push_back(0);
            acc_cyc = cyc;
         end
         if (r1_valid && r1_ready) begin
            sb_q.push_back(model(r1_a, r1_b, r1_sub, 1'b1));
            acc_ids.push_back(1);
            acc_cyc = cyc;
         end
         if (rsp_valid && !prev_rsp_valid)
            chk("latency", 64'(cyc - acc_cyc), 64'(WORDS + 1));
         if (rsp_valid && rsp_ready) begin
            rsp_hs_cyc = cyc;
            if (sb_q.size() == 0) begin
               chk("stale_rsp", 1, 0);
            end else begin
               e = sb_q.pop_front();
               $display("rsp id=%0d sum=%08h cout=%0d ovf=%0d", rsp_id, rsp_sum, rsp_cout, rsp_ovf);
               chk("rsp_sum", 64'(rsp_sum), 64'(e.sum));
               chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
               chk("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
               chk("rsp_id", 64'(rsp_id), 64'(e.id));
            end
         end
      end
      prev_rsp_valid = rsp_valid;
   end

   task automatic send(input int who, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      logic got = 1'b0;
      if (who == 0) begin r0_a = a; r0_b = b; r0_sub = sub; r0_valid = 1'b1; end
      else          begin r1_a = a; r1_b = b; r1_sub = sub; r1_valid = 1'b1; end
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         got = (who == 0) ? r0_ready : r1_ready;
      end
      if (!got) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      if (who == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb_q.size() != 0 || rsp_valid) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) chk("drain_timeout", 0, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      sb_q.delete();
      acc_ids.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   logic [W-1:0] va [7] = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'd7, 32'h80000000, 32'h12345678};
   logic [W-1:0] vb [7] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'd7, 32'd5, 32'h00000001, 32'hFEDCBA98};
   logic         vs [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   initial begin
      int   left0, left1, n;
      logic acc0, acc1, got;
      logic [W+3:0] snap;

      rst = 1'b1; rsp_ready = 1'b1;
      r0_valid = 1'b1; r1_valid = 1'b1; r0_sub = 1'b0; r1_sub = 1'b0;
      r0_a = 32'h01020304; r0_b = 32'h05060708; r1_a = 32'h11111111; r1_b = 32'h22222222;
      #12;
      chk("rst_r0_ready", 64'(r0_ready), 0);
      chk("rst_r1_ready", 64'(r1_ready), 0);
      chk("rst_rsp_valid", 64'(rsp_valid), 0);
      chk("rst_add_a", 64'(add_a), 0);
      chk("rst_add_cin", 64'(add_cin), 0);
      chk("rst_rsp_sum", 64'(rsp_sum), 0);
      r0_valid = 1'b0; r1_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;

      // Directed add/subtract vectors through requester 0.
      for (int i = 0; i < 7; i++) begin
         send(0, va[i], vb[i], vs[i]);
         wait_drain();
      end

      // Both requesters valid from reset release, four requests each.
      r0_valid = 1'b1; r1_valid = 1'b1;
      r0_a = $urandom; r0_b = $urandom; r1_a = $urandom; r1_b = $urandom;
      r0_sub = 1'b0; r1_sub = 1'b1;
      do_reset();
      left0 = 4; left1 = 4; n = 0;
      while ((left0 > 0 || left1 > 0) && n < 200) begin
         @(negedge clk);
         acc0 = r0_valid && r0_ready;
         acc1 = r1_valid && r1_ready;
         @(posedge clk); #1;
         if (acc0) begin
            left0--;
            r0_a = $urandom; r0_b = $urandom; r0_sub = 1'($urandom_range(0, 1));
            if (left0 == 0) r0_valid = 1'b0;
         end
         if (acc1) begin
            left1--;
            r1_a = $urandom; r1_b = $urandom; r1_sub = 1'($urandom_range(0, 1));
            if (left1 == 0) r1_valid = 1'b0;
         end
         n++;
      end
      wait_drain();
      chk("arb_count", 64'(acc_ids.size()), 8);
      for (int i = 0; i < 8 && i < acc_ids.size(); i++)
         chk("arb_order", 64'(acc_ids[i]), 64'(i % 2));

      // Lone requester gets consecutive grants.
      acc_ids.delete();
      send(1, 32'h00010000, 32'h0000FFFF, 1'b0);
      wait_drain();
      send(1, 32'h00000000, 32'h00000001, 1'b1);
      wait_drain();
      chk("solo_count", 64'(acc_ids.size()), 2);
      for (int i = 0; i < 2 && i < acc_ids.size(); i++)
         chk("solo_id", 64'(acc_ids[i]), 1);

      // Backpressure in DONE.
      rsp_ready = 1'b0;
      send(0, 32'h12345678, 32'h11111111, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = rsp_valid;
      end
      chk("bp_valid", 64'(got), 1);
      snap = {rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id};
      r0_a = 32'h0000AAAA; r0_b = 32'h00005555; r0_valid = 1'b1;
      r1_a = 32'h00C0FFEE; r1_b = 32'h00000011; r1_sub = 1'b1; r1_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_hold", 64'({rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id}), 64'(snap));
         chk("bp_r0_ready", 64'(r0_ready), 0);
         chk("bp_r1_ready", 64'(r1_ready), 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      r0_valid = 1'b0;
      send(1, 32'h00C0FFEE, 32'h00000011, 1'b1);
      chk("resume_gap", 64'(acc_cyc - rsp_hs_cyc), 1);
      wait_drain();

      // Asynchronous reset in the middle of RUN.
      r0_a = 32'hA1B2C3D4; r0_b = 32'h01020304; r0_sub = 1'b0; r0_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = r0_ready;
      end
      chk("rr_accept", 64'(got), 1);
      @(posedge clk); #1 r0_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("run_idx2_a", 64'(add_a), 64'h B2);
      chk("run_idx2_b", 64'(add_b), 64'h 02);
      r0_a = 32'h00000010; r0_b = 32'h00000020; r0_valid = 1'b1;
      r1_a = 32'h00000300; r1_b = 32'h00000400; r1_sub = 1'b0; r1_valid = 1'b1;
      rst = 1'b1;
      #1;
      chk("arst_add_a", 64'(add_a), 0);
      chk("arst_add_b", 64'(add_b), 0);
      chk("arst_add_cin", 64'(add_cin), 0);
      chk("arst_rsp_valid", 64'(rsp_valid), 0);
      chk("arst_r0_ready", 64'(r0_ready), 0);
      chk("arst_r1_ready", 64'(r1_ready), 0);
      sb_q.delete();
      acc_ids.delete();
      @(posedge clk); #1 rst = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = r0_ready || r1_ready;
      end
      @(posedge clk); #1;
      r0_valid = 1'b0; r1_valid = 1'b0;
      chk("post_rst_accept", 64'(got), 1);
      chk("post_rst_count", 64'(acc_ids.size()), 1);
      if (acc_ids.size() > 0) chk("post_rst_grant", 64'(acc_ids[0]), 0);
      wait_drain();

      chk("sb_empty", 64'(sb_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/csa_seq_ctrl.md
Name: csa_seq_ctrl

Overview:
- Sequencer and arbiter that shares one external 8-bit carry-skip adder slice between two requesters.
- Each request is a multi-byte add or subtract. The block drives the slice one byte per cycle, least significant byte first, and chains the carry through an internal register.
- Returns the full-width sum, carry-out, signed overflow and requester id over a valid/ready response channel.
- Sits between the requesting units and the combinational 8-bit adder slice.

Parameters:
- WORDS, 4, number of 8-bit bytes per operand; operand width W = 8*WORDS; legal range 1..16.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- r0_valid  in  1  requester 0 has a request.
- r0_ready  out  1  requester 0 request accepted this cycle.
- r0_a  in  W  requester 0 operand A.
- r0_b  in  W  requester 0 operand B.
- r0_sub  in  1  requester 0 operation: 1 = A-B, 0 = A+B.
- r1_valid, r1_ready, r1_a, r1_b, r1_sub  same as above, for requester 1.
- add_a  out  8  slice operand A byte.
- add_b  out  8  slice operand B byte; already inverted when subtracting.
- add_cin  out  1  slice carry-in.
- add_sum  in  8  slice sum; combinational from add_a, add_b, add_cin.
- add_cout  in  1  slice carry-out; combinational.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  W  result.
- rsp_cout  out  1  final carry-out; for subtract, 1 = no borrow.
- rsp_ovf  out  1  two's-complement overflow.
- rsp_id  out  1  id of the requester that was served.

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high. While rst is high:
  - state = IDLE.
  - All outputs are 0: r*_ready, add_*, rsp_*.
  - Byte index, carry register and result register are 0.
  - Round-robin pointer last = 1, so r0 wins the first contention.
- FSM states:
  - IDLE: accept a request.
  - RUN: drive the slice one byte per cycle.
  - DONE: present the result.
- IDLE:
  - rr_arb2 picks a grant from r0_valid, r1_valid and last.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester != last is granted.
  - rx_ready = grant to that requester, driven combinationally, high only in IDLE.
  - On handshake (valid & ready):
    - Latch A into opA.
    - Latch B ^ {W{sub}} into opB.
    - Latch sub and id.
    - Set last <= id and idx <= 0, then go to RUN.
  - With no valid request, stay in IDLE.
- RUN, byte idx:
  - add_a = opA[8*idx +: 8].
  - add_b = opB[8*idx +: 8].
  - add_cin = sub when idx == 0, otherwise carry_q.
  - Each cycle: res[8*idx +: 8] <= add_sum, carry_q <= add_cout, idx <= idx+1.
  - On the cycle with idx == WORDS-1:
    - Compute ovf = (opA[W-1] == opB[W-1]) && (add_sum[7] != opA[W-1]).
    - Go to DONE.
  - add_* are 0 outside RUN.
- DONE:
  - rsp_valid = 1, with rsp_sum = res, rsp_cout = carry_q, rsp_ovf and rsp_id.
  - All rsp_* stay stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE. No new request is accepted in DONE.
- Latency and throughput:
  - Handshake at cycle T; bytes are processed at cycles T+1 .. T+WORDS; rsp_valid first rises at T+WORDS+1.
  - Minimum spacing between accepts is WORDS+2 cycles.
- Width rules:
  - The result is modulo 2^W.
  - Carry is threaded only through carry_q; there are no skip or lookahead paths in the controller.
- Boundary conditions:
  - WORDS = 1: RUN lasts exactly one cycle.
  - A requester's valid dropping while it is not granted: no state effect.
  - Operands changing after the handshake: ignored, because they are latched.
  - rst mid-RUN or mid-DONE: the operation is lost immediately and no response is issued.
  - Both requesters valid continuously: grants strictly alternate.

Decomposition:
- Package csa_seq_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - BYTE_W = 8.
  - ID_R0 = 0, ID_R1 = 1.
- One sub-module, rr_arb2, is natural: a 2-way round-robin grant function of (valid[1:0], last) giving (grant[1:0], id).
  - It is combinational; the last register stays in csa_seq_ctrl.

Test Plan:
- Basic add, WORDS=4, r0 only: A=0x000000FF, B=0x00000001, add.
  - Required: rsp_sum=0x00000100, cout=0, ovf=0, id=0.
  - rsp_valid rises exactly 5 cycles after the handshake.
- Carry and overflow:
  - 0xFFFFFFFF+0x00000001 -> sum=0x00000000, cout=1, ovf=0.
  - 0x7FFFFFFF+0x00000001 -> sum=0x80000000, cout=0, ovf=1.
- Subtract:
  - 5-7 -> sum=0xFFFFFFFE, cout=0, ovf=0.
  - 7-5 -> sum=0x00000002, cout=1.
  - 0x80000000-1 -> sum=0x7FFFFFFF, ovf=1.
- Arbitration: r0 and r1 held valid from reset release, 4 requests each.
  - Accept order is 0,1,0,1,...
  - rsp_id matches the accept order.
  - A single valid requester is granted on consecutive accepts.
- Backpressure: rsp_ready held low for 3 cycles in DONE.
  - rsp_* remain stable.
  - r0_ready and r1_ready stay 0.
  - Accept resumes the cycle after the rsp handshake returns the block to IDLE.
- Reset during RUN at idx=2: assert rst asynchronously.
  - All outputs are 0 without waiting for a clock edge.
  - After release, the state is IDLE and the next contention grants r0.
  - No stale response appears.
